mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 17 +
 rtl/mem_stage_ctrl.sv | 116 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings for the MEM-stage controller: result-select codes and FSM states.
package mem_stage_ctrl_pkg;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;
  localparam logic [1:0] SEL_HI  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: handshakes data-memory requests, holds load data until WB
// accepts it, and drains responses orphaned by a flush.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_to_mem_valid,
  input  logic        wb_allowin,
  input  logic        flush,
  input  logic        dmem_we,
  input  logic        rf_we,
  input  logic [1:0]  rd_mux_sel,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [4:0]  rdc_mem,
  input  logic        ex,
  input  logic        eret_flush,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_addr_ok,
  input  logic        dmem_data_ok,
  input  logic [31:0] dmem_rdata,
  output logic        mem_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_result,
  output logic        fwd_valid,
  output logic        fwd_ready,
  output logic [4:0]  fwd_rdc
);

  logic       r_mem_valid;
  mem_state_t r_state;
  logic [31:0] r_rbuf;

  logic       w_access;
  mem_state_t w_st;
  logic       w_wait_dok;
  logic       w_ready_go;

  assign w_access = r_mem_valid & ~ex & ~eret_flush & (dmem_we | (rd_mux_sel == SEL_MEM));

  // A fresh access behaves as REQ in its first valid cycle, so the request
  // goes out without a dead IDLE cycle.
  assign w_st = (r_state == ST_IDLE && w_access && !flush) ? ST_REQ : r_state;

  assign w_wait_dok = (w_st == ST_WAIT) & dmem_data_ok;
  assign w_ready_go = ~w_access | w_wait_dok | (w_st == ST_DONE);

  assign dmem_req   = (w_st == ST_REQ);
  assign dmem_wr    = dmem_we;
  assign dmem_addr  = alu_result;
  assign dmem_wdata = rt;

  assign mem_to_wb_valid = r_mem_valid & w_ready_go & ~flush;
  assign mem_allowin     = (~r_mem_valid | (w_ready_go & wb_allowin)) & (r_state != ST_CANCEL);

  assign fwd_valid = r_mem_valid & rf_we & ~ex;
  assign fwd_ready = w_ready_go;
  assign fwd_rdc   = rdc_mem;

  always_comb begin
    mem_result = alu_result;
    case (rd_mux_sel)
      SEL_ALU: mem_result = alu_result;
      SEL_MEM: mem_result = (w_st == ST_DONE) ? r_rbuf : dmem_rdata;
      SEL_LO:  mem_result = lo;
      SEL_HI:  mem_result = hi;
      default: mem_result = alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_valid <= 1'b0;
      r_state     <= ST_IDLE;
      r_rbuf      <= 32'h0;
    end else begin
      if (flush)            r_mem_valid <= 1'b0;
      else if (mem_allowin) r_mem_valid <= exe_to_mem_valid;

      r_state <= w_st;
      case (w_st)
        ST_REQ: begin
          // An accepted request must still have its response drained.
          if (dmem_addr_ok)  r_state <= flush ? ST_CANCEL : ST_WAIT;
          else if (flush)    r_state <= ST_IDLE;
        end
        ST_WAIT: begin
          if (dmem_data_ok) begin
            if (flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_rbuf  <= dmem_rdata;
              r_state <= wb_allowin ? ST_IDLE : ST_DONE;
            end
          end else if (flush) begin
            r_state <= ST_CANCEL;
          end
        end
        ST_DONE: begin
          if (wb_allowin || flush) r_state <= ST_IDLE;
        end
        ST_CANCEL: begin
          if (dmem_data_ok) r_state <= ST_IDLE;
        end
        default: r_state <= w_st;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Cycle-by-cycle vector table for mem_stage_ctrl plus a hand-written reset-in-REQ sequence.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_to_mem_valid, wb_allowin, flush;
  logic        dmem_we, rf_we, ex, eret_flush;
  logic [1:0]  rd_mux_sel;
  logic [31:0] alu_result, rt, lo, hi;
  logic [4:0]  rdc_mem;
  logic        dmem_req, dmem_wr;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_addr_ok, dmem_data_ok;
  logic [31:0] dmem_rdata;
  logic        mem_allowin, mem_to_wb_valid;
  logic [31:0] mem_result;
  logic        fwd_valid, fwd_ready;
  logic [4:0]  fwd_rdc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .exe_to_mem_valid(exe_to_mem_valid), .wb_allowin(wb_allowin), .flush(flush),
    .dmem_we(dmem_we), .rf_we(rf_we), .rd_mux_sel(rd_mux_sel),
    .alu_result(alu_result), .rt(rt), .lo(lo), .hi(hi), .rdc_mem(rdc_mem),
    .ex(ex), .eret_flush(eret_flush),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_addr_ok(dmem_addr_ok), .dmem_data_ok(dmem_data_ok), .dmem_rdata(dmem_rdata),
    .mem_allowin(mem_allowin), .mem_to_wb_valid(mem_to_wb_valid), .mem_result(mem_result),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_rdc(fwd_rdc)
  );

  typedef struct {
    logic        ev, wa, fl;
    logic [1:0]  sel;
    logic        we, ex, aok, dok;
    logic [31:0] alu, rdata;
    logic        xreq, xallow, xv2wb;
    logic [31:0] xres;
    logic        xfwdv, xfwdr;
  } vec_t;

  vec_t vt[32];

  function automatic vec_t mk(input logic ev, wa, fl, input logic [1:0] sel,
                              input logic we, xe, aok, dok, input logic [31:0] alu, rdata,
                              input logic xreq, xallow, xv2wb, input logic [31:0] xres,
                              input logic xfwdv, xfwdr);
    vec_t v;
    v.ev = ev; v.wa = wa; v.fl = fl; v.sel = sel; v.we = we; v.ex = xe;
    v.aok = aok; v.dok = dok; v.alu = alu; v.rdata = rdata;
    v.xreq = xreq; v.xallow = xallow; v.xv2wb = xv2wb; v.xres = xres;
    v.xfwdv = xfwdv; v.xfwdr = xfwdr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    exe_to_mem_valid = 0; wb_allowin = 1; flush = 0;
    dmem_we = 0; rf_we = 1; ex = 0; eret_flush = 0; rd_mux_sel = 2'b00;
    alu_result = 0; rt = 32'h55AA; lo = 32'h10; hi = 32'h20; rdc_mem = 5'd7;
    dmem_addr_ok = 0; dmem_data_ok = 0; dmem_rdata = 0;

    //          ev wa fl sel   we ex aok dok alu         rdata         req al v2 res           fv fr
    vt[0]  = mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 0, 32'h0,        0, 1);
    vt[1]  = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h1234,   32'h0,        0, 1, 0, 32'h1234,     0, 1);
    vt[2]  = mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 32'h1234,   32'h0,        0, 1, 1, 32'h1234,     1, 1);
    vt[3]  = mk(1, 1, 0, 2'b01, 0, 0, 0, 0, 32'h100,    32'h0,        0, 1, 0, 32'h0,        0, 1);
    vt[4]  = mk(0, 1, 0, 2'b01, 0, 0, 0, 0, 32'h100,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[5]  = mk(0, 1, 0, 2'b01, 0, 0, 0, 0, 32'h100,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[6]  = mk(0, 1, 0, 2'b01, 0, 0, 1, 0, 32'h100,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[7]  = mk(1, 1, 0, 2'b01, 0, 0, 0, 1, 32'h100,    32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF, 1, 1);
    vt[8]  = mk(0, 0, 0, 2'b01, 0, 0, 1, 0, 32'h200,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[9]  = mk(0, 0, 0, 2'b01, 0, 0, 0, 1, 32'h200,    32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 1, 1);
    vt[10] = mk(0, 0, 0, 2'b01, 0, 0, 0, 0, 32'h200,    32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 1);
    vt[11] = mk(0, 0, 0, 2'b01, 0, 0, 0, 0, 32'h200,    32'h0,        0, 0, 1, 32'hDEADBEEF, 1, 1);
    vt[12] = mk(1, 1, 0, 2'b01, 0, 0, 0, 0, 32'h200,    32'h0,        0, 1, 1, 32'hDEADBEEF, 1, 1);
    vt[13] = mk(0, 1, 0, 2'b00, 1, 1, 0, 0, 32'h300,    32'h0,        0, 1, 1, 32'h300,      0, 1);
    vt[14] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 0, 32'h0,        0, 1);
    vt[15] = mk(0, 1, 0, 2'b00, 1, 0, 1, 0, 32'h400,    32'h0,        1, 0, 0, 32'h400,      0, 0);
    vt[16] = mk(1, 1, 0, 2'b00, 1, 0, 0, 1, 32'h400,    32'h0,        0, 1, 1, 32'h400,      0, 1);
    vt[17] = mk(0, 1, 0, 2'b01, 0, 0, 1, 0, 32'h500,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[18] = mk(0, 1, 1, 2'b01, 0, 0, 0, 0, 32'h500,    32'h0,        0, 0, 0, 32'h0,        1, 0);
    vt[19] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 0, 0, 32'h0,        0, 1);
    vt[20] = mk(1, 1, 0, 2'b00, 0, 0, 0, 1, 32'h0,      32'hBAD0BAD0, 0, 0, 0, 32'h0,        0, 1);
    vt[21] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 0, 32'h0,        0, 1);
    vt[22] = mk(1, 1, 0, 2'b10, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 1, 32'h10,       1, 1);
    vt[23] = mk(0, 1, 0, 2'b11, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 1, 32'h20,       1, 1);
    vt[24] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 0, 32'h0,        0, 1);
    vt[25] = mk(0, 1, 0, 2'b01, 0, 0, 1, 0, 32'h600,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[26] = mk(0, 1, 1, 2'b01, 0, 0, 0, 1, 32'h600,    32'h0000CAFE, 0, 1, 0, 32'h0000CAFE, 1, 1);
    vt[27] = mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 0, 32'h0,        0, 1);
    vt[28] = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 0, 32'h0,        0, 1);
    vt[29] = mk(0, 1, 0, 2'b01, 0, 0, 0, 0, 32'h700,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[30] = mk(0, 1, 1, 2'b01, 0, 0, 0, 0, 32'h700,    32'h0,        1, 0, 0, 32'h0,        1, 0);
    vt[31] = mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,        0, 1, 0, 32'h0,        0, 1);

    #2;
    chk("rst dmem_req",        {31'b0, dmem_req},        32'd0);
    chk("rst mem_to_wb_valid", {31'b0, mem_to_wb_valid}, 32'd0);
    chk("rst mem_allowin",     {31'b0, mem_allowin},     32'd1);
    chk("rst fwd_valid",       {31'b0, fwd_valid},       32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 32; i++) begin
      exe_to_mem_valid = vt[i].ev; wb_allowin = vt[i].wa; flush = vt[i].fl;
      rd_mux_sel = vt[i].sel; dmem_we = vt[i].we; rf_we = ~vt[i].we; ex = vt[i].ex;
      dmem_addr_ok = vt[i].aok; dmem_data_ok = vt[i].dok;
      alu_result = vt[i].alu; dmem_rdata = vt[i].rdata;
      #2;
      chk($sformatf("row%0d dmem_req", i),        {31'b0, dmem_req},        {31'b0, vt[i].xreq});
      chk($sformatf("row%0d mem_allowin", i),     {31'b0, mem_allowin},     {31'b0, vt[i].xallow});
      chk($sformatf("row%0d mem_to_wb_valid", i), {31'b0, mem_to_wb_valid}, {31'b0, vt[i].xv2wb});
      chk($sformatf("row%0d mem_result", i),      mem_result,               vt[i].xres);
      chk($sformatf("row%0d fwd_valid", i),       {31'b0, fwd_valid},       {31'b0, vt[i].xfwdv});
      chk($sformatf("row%0d fwd_ready", i),       {31'b0, fwd_ready},       {31'b0, vt[i].xfwdr});
      chk($sformatf("row%0d dmem_addr", i),       dmem_addr,                vt[i].alu);
      chk($sformatf("row%0d dmem_wr", i),         {31'b0, dmem_wr},         {31'b0, vt[i].we});
      tick();
    end
    chk("dmem_wdata", dmem_wdata, 32'h55AA);
    chk("fwd_rdc",    {27'b0, fwd_rdc}, 32'd7);

    // Reset asserted while a load is sitting in REQ.
    exe_to_mem_valid = 1; wb_allowin = 1; flush = 0; rd_mux_sel = 2'b01;
    dmem_we = 0; rf_we = 1; ex = 0; dmem_addr_ok = 0; dmem_data_ok = 0;
    alu_result = 32'h800; dmem_rdata = 0;
    tick();
    exe_to_mem_valid = 0;
    #2;
    chk("preRst dmem_req", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midRst dmem_req",        {31'b0, dmem_req},        32'd0);
    chk("midRst mem_allowin",     {31'b0, mem_allowin},     32'd1);
    chk("midRst mem_to_wb_valid", {31'b0, mem_to_wb_valid}, 32'd0);
    chk("midRst fwd_valid",       {31'b0, fwd_valid},       32'd0);
    tick();
    rst = 1'b0;
    dmem_data_ok = 1; dmem_rdata = 32'h1111_2222;
    #2;
    chk("postRst dmem_req",        {31'b0, dmem_req},        32'd0);
    chk("postRst mem_allowin",     {31'b0, mem_allowin},     32'd1);
    chk("postRst mem_to_wb_valid", {31'b0, mem_to_wb_valid}, 32'd0);
    tick();
    dmem_data_ok = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
